// File: rtl/alu_pkg.sv
// Shared constants for the ALU arbiter: data width, ALU opcodes
// and the controller state encoding.
package alu_pkg;

    localparam int DW = 32;

    localparam logic [3:0] OP_OR     = 4'd0;
    localparam logic [3:0] OP_AND    = 4'd1;
    localparam logic [3:0] OP_XOR    = 4'd2;
    localparam logic [3:0] OP_ADD    = 4'd3;
    localparam logic [3:0] OP_SUB    = 4'd4;
    localparam logic [3:0] OP_SHIFTL = 4'd5;
    localparam logic [3:0] OP_SHIFTR = 4'd6;
    localparam logic [3:0] OP_MULT   = 4'd7;
    localparam logic [3:0] OP_NOTA   = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: logic, add/sub, shifts, low-word multiply,
// optional pass-through of b, plus b>a and b==a compare flags.
module ALU
    import alu_pkg::*;
(
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic [3:0]    i_opcode,
    input  logic          i_skip,
    output logic [DW-1:0] o_y,
    output logic          o_bga,
    output logic          o_bea
);

    logic [DW-1:0] w_res;

    // Opcode decode; shift amounts of 32..63 flush to zero.
    always_comb begin
        w_res = '0;
        case (i_opcode)
            OP_OR:     w_res = i_a | i_b;
            OP_AND:    w_res = i_a & i_b;
            OP_XOR:    w_res = i_a ^ i_b;
            OP_ADD:    w_res = i_a + i_b;
            OP_SUB:    w_res = i_a - i_b;
            OP_SHIFTL: w_res = i_b[5] ? '0 : (i_a << i_b[4:0]);
            OP_SHIFTR: w_res = i_b[5] ? '0 : (i_a >> i_b[4:0]);
            OP_MULT:   w_res = i_a * i_b;
            OP_NOTA:   w_res = ~i_a;
            default:   w_res = '0;
        endcase
    end

    assign o_y   = i_skip ? i_b : w_res;
    assign o_bga = (i_b > i_a);
    assign o_bea = (i_b == i_a);

endmodule

// File: rtl/alu_arbiter.sv
// Two-port valid/ready front end sharing one ALU; one operation in
// flight, result held until the owning port takes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic          req1_valid,
    output logic          req0_ready,
    output logic          req1_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    input  logic [3:0]    req0_opcode,
    input  logic [3:0]    req1_opcode,
    input  logic          req0_skip,
    input  logic          req1_skip,
    output logic          rsp0_valid,
    output logic          rsp1_valid,
    input  logic          rsp0_ready,
    input  logic          rsp1_ready,
    output logic [DW-1:0] rsp_y,
    output logic          rsp_bga,
    output logic          rsp_bea,
    output logic          busy
);

    state_t        r_state;
    state_t        w_state_nxt;

    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [3:0]    r_op;
    logic          r_skip;
    logic          r_id;
    logic          r_last_grant;

    logic [DW-1:0] r_y;
    logic          r_bga;
    logic          r_bea;

    logic          w_gnt_id;
    logic          w_accept;
    logic          w_rsp_hs;
    logic [DW-1:0] w_a;
    logic [DW-1:0] w_b;
    logic [3:0]    w_op;
    logic          w_skip;
    logic [DW-1:0] w_alu_y;
    logic          w_alu_bga;
    logic          w_alu_bea;

    // Pick a winner: lone requester wins, otherwise fixed or rotating.
    always_comb begin
        w_gnt_id = req1_valid;
        if (req0_valid && req1_valid) begin
            w_gnt_id = PRIO_FIXED ? 1'b0 : ~r_last_grant;
        end
    end

    assign w_accept = (r_state == IDLE) && (req0_valid || req1_valid);
    assign w_rsp_hs = (r_state == RESP) &&
                      (r_id ? rsp1_ready : rsp0_ready);

    assign w_a    = w_gnt_id ? req1_a      : req0_a;
    assign w_b    = w_gnt_id ? req1_b      : req0_b;
    assign w_op   = w_gnt_id ? req1_opcode : req0_opcode;
    assign w_skip = w_gnt_id ? req1_skip   : req0_skip;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: capture, compute, then wait for the owner's ready.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = RESP;
            RESP:    if (w_rsp_hs) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture on acceptance; grant history feeds round-robin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_skip       <= 1'b0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_a          <= w_a;
            r_b          <= w_b;
            r_op         <= w_op;
            r_skip       <= w_skip;
            r_id         <= w_gnt_id;
            r_last_grant <= w_gnt_id;
        end
    end

    ALU u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_opcode (r_op),
        .i_skip   (r_skip),
        .o_y      (w_alu_y),
        .o_bga    (w_alu_bga),
        .o_bea    (w_alu_bea)
    );

    // Result registers load once per op and hold through RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_y   <= '0;
            r_bga <= 1'b0;
            r_bea <= 1'b0;
        end else if (r_state == EXEC) begin
            r_y   <= w_alu_y;
            r_bga <= w_alu_bga;
            r_bea <= w_alu_bea;
        end
    end

    assign req0_ready = w_accept && !w_gnt_id;
    assign req1_ready = w_accept &&  w_gnt_id;
    assign rsp0_valid = (r_state == RESP) && !r_id;
    assign rsp1_valid = (r_state == RESP) &&  r_id;
    assign rsp_y      = r_y;
    assign rsp_bga    = r_bga;
    assign rsp_bea    = r_bea;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share
// the same stimulus; each task checks its own scenario.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid = 0, req1_valid = 0;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [3:0]  req0_opcode = 0, req1_opcode = 0;
    logic        req0_skip = 0, req1_skip = 0;
    logic        rsp0_ready = 0, rsp1_ready = 0;

    logic        rr_req0_ready, rr_req1_ready, rr_rsp0_valid;
    logic        rr_rsp1_valid, rr_rsp_bga, rr_rsp_bea, rr_busy;
    logic [31:0] rr_rsp_y;
    logic        fx_req0_ready, fx_req1_ready, fx_rsp0_valid;
    logic        fx_rsp1_valid, fx_rsp_bga, fx_rsp_bea, fx_busy;
    logic [31:0] fx_rsp_y;
    logic [6:0]  rr_ctl, fx_ctl;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // {busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid, bga, bea}
    assign rr_ctl = {rr_busy, rr_req0_ready, rr_req1_ready,
                     rr_rsp0_valid, rr_rsp1_valid, rr_rsp_bga, rr_rsp_bea};
    assign fx_ctl = {fx_busy, fx_req0_ready, fx_req1_ready,
                     fx_rsp0_valid, fx_rsp1_valid, fx_rsp_bga, fx_rsp_bea};

    alu_arbiter #(.PRIO_FIXED(1'b0)) u_rr (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(rr_req0_ready), .req1_ready(rr_req1_ready),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_a(req1_a), .req1_b(req1_b),
        .req0_opcode(req0_opcode), .req1_opcode(req1_opcode),
        .req0_skip(req0_skip), .req1_skip(req1_skip),
        .rsp0_valid(rr_rsp0_valid), .rsp1_valid(rr_rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_y(rr_rsp_y), .rsp_bga(rr_rsp_bga), .rsp_bea(rr_rsp_bea),
        .busy(rr_busy)
    );

    alu_arbiter #(.PRIO_FIXED(1'b1)) u_fx (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(fx_req0_ready), .req1_ready(fx_req1_ready),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_a(req1_a), .req1_b(req1_b),
        .req0_opcode(req0_opcode), .req1_opcode(req1_opcode),
        .req0_skip(req0_skip), .req1_skip(req1_skip),
        .rsp0_valid(fx_rsp0_valid), .rsp1_valid(fx_rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_y(fx_rsp_y), .rsp_bga(fx_rsp_bga), .rsp_bea(fx_rsp_bea),
        .busy(fx_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs;
        req0_valid = 0; req1_valid = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        req0_skip = 0; req1_skip = 0;
    endtask

    task automatic pulse_reset;
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // Port-0 transaction with bounded waits; ok=0 on timeout.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic sk,
                         output logic [31:0] y, output logic [1:0] fl,
                         output bit ok);
        int n;
        ok = 1;
        req0_a = a; req0_b = b; req0_opcode = op; req0_skip = sk;
        req0_valid = 1;
        #1;
        n = 0;
        while (!rr_req0_ready && n < 10) begin tick(); n++; end
        if (!rr_req0_ready) ok = 0;
        tick();
        req0_valid = 0; req0_skip = 0;
        #1;
        n = 0;
        while (!rr_rsp0_valid && n < 10) begin tick(); n++; end
        if (!rr_rsp0_valid) ok = 0;
        y = rr_rsp_y;
        fl = {rr_rsp_bga, rr_rsp_bea};
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
    endtask

    task automatic test_reset;
        quiet_inputs();
        reset = 1'b0;
        tick(); tick();
        n_checks++;
        if (rr_ctl !== 7'b0 || rr_rsp_y !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_rr ctl=%b y=%h want 0", rr_ctl, rr_rsp_y);
        end
        n_checks++;
        if (fx_ctl !== 7'b0 || fx_rsp_y !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_fx ctl=%b y=%h want 0", fx_ctl, fx_rsp_y);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (rr_ctl !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_release ctl=%b want 0", rr_ctl);
        end
    endtask

    task automatic test_single;
        req0_a = 5; req0_b = 7; req0_opcode = OP_ADD; req0_valid = 1;
        #1;
        n_checks++;
        if (rr_ctl !== 7'b0100000) begin
            n_fail++;
            $display("FAIL single_accept ctl=%b want 0100000", rr_ctl);
        end
        tick();
        req0_valid = 0;
        #1;
        n_checks++;
        if (rr_ctl !== 7'b1000000) begin
            n_fail++;
            $display("FAIL single_exec ctl=%b want 1000000", rr_ctl);
        end
        tick();
        n_checks++;
        if (rr_ctl !== 7'b1001010 || rr_rsp_y !== 32'd12) begin
            n_fail++;
            $display("FAIL single_resp ctl=%b y=%0d want 1001010 y=12",
                     rr_ctl, rr_rsp_y);
        end
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
        n_checks++;
        if (rr_ctl !== 7'b0000010 || rr_rsp_y !== 32'd12) begin
            n_fail++;
            $display("FAIL single_done ctl=%b y=%0d want 0000010 y=12",
                     rr_ctl, rr_rsp_y);
        end
    endtask

    task automatic test_contention;
        logic [6:0]  exp_rr [9];
        logic [6:0]  exp_fx [9];
        logic [31:0] ey_rr [9];
        exp_rr = '{7'b0100000, 7'b1000000, 7'b1001000,
                   7'b0010000, 7'b1000000, 7'b1000100,
                   7'b0100000, 7'b1000000, 7'b1001000};
        exp_fx = '{7'b0100000, 7'b1000000, 7'b1001000,
                   7'b0100000, 7'b1000000, 7'b1001000,
                   7'b0100000, 7'b1000000, 7'b1001000};
        ey_rr = '{0, 0, 32'd7, 0, 0, 32'hFF, 0, 0, 32'd7};
        quiet_inputs();
        pulse_reset();
        req0_a = 10;    req0_b = 3;    req0_opcode = OP_SUB;
        req1_a = 'hF0;  req1_b = 'h0F; req1_opcode = OP_XOR;
        req0_valid = 1; req1_valid = 1;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int c = 0; c < 9; c++) begin
            #1;
            n_checks++;
            if (rr_ctl !== exp_rr[c]) begin
                n_fail++;
                $display("FAIL rr_cycle%0d ctl=%b want %b",
                         c, rr_ctl, exp_rr[c]);
            end
            n_checks++;
            if (fx_ctl !== exp_fx[c]) begin
                n_fail++;
                $display("FAIL fx_cycle%0d ctl=%b want %b",
                         c, fx_ctl, exp_fx[c]);
            end
            if (c % 3 == 2) begin
                n_checks++;
                if (rr_rsp_y !== ey_rr[c]) begin
                    n_fail++;
                    $display("FAIL rr_y%0d y=%h want %h",
                             c, rr_rsp_y, ey_rr[c]);
                end
                n_checks++;
                if (fx_rsp_y !== 32'd7) begin
                    n_fail++;
                    $display("FAIL fx_y%0d y=%h want 7", c, fx_rsp_y);
                end
            end
            tick();
        end
        quiet_inputs();
    endtask

    task automatic test_backpressure;
        quiet_inputs();
        pulse_reset();
        req1_a = 'h10000; req1_b = 'h10000; req1_opcode = OP_MULT;
        req1_valid = 1;
        #1;
        n_checks++;
        if (rr_ctl !== 7'b0010000) begin
            n_fail++;
            $display("FAIL bp_accept ctl=%b want 0010000", rr_ctl);
        end
        tick();
        req1_valid = 0;
        req0_a = 1; req0_b = 2; req0_opcode = OP_ADD; req0_valid = 1;
        rsp0_ready = 1;
        tick();
        for (int c = 0; c < 6; c++) begin
            if (c == 5) rsp1_ready = 1;
            #1;
            n_checks++;
            if (rr_ctl !== 7'b1000101 || rr_rsp_y !== 32'd0) begin
                n_fail++;
                $display("FAIL bp_hold%0d ctl=%b y=%h want 1000101 y=0",
                         c, rr_ctl, rr_rsp_y);
            end
            tick();
        end
        rsp1_ready = 0;
        #1;
        n_checks++;
        if (rr_ctl !== 7'b0100001) begin
            n_fail++;
            $display("FAIL bp_next_accept ctl=%b want 0100001", rr_ctl);
        end
        tick();
        req0_valid = 0;
        tick();
        n_checks++;
        if (rr_ctl !== 7'b1001010 || rr_rsp_y !== 32'd3) begin
            n_fail++;
            $display("FAIL bp_p0_resp ctl=%b y=%h want 1001010 y=3",
                     rr_ctl, rr_rsp_y);
        end
        tick();
        quiet_inputs();
    endtask

    task automatic test_edge_ops;
        logic [31:0] ta [13];
        logic [31:0] tb [13];
        logic [3:0]  top [13];
        logic        tsk [13];
        logic [31:0] tey [13];
        logic [1:0]  tef [13];
        logic [31:0] y;
        logic [1:0]  fl;
        bit          ok;
        ta  = '{1, 5, 3, 1, 'h80000000, 1, 'h0F0F0F0F, 3,
                'hFFFFFFFF, 'hF0F0, 'hF000, 'hFFFFFFFF, 'h80000000};
        tb  = '{'hDEADBEEF, 6, 3, 40, 31, 31, 0, 5,
                2, 'h0FF0, 'h000F, 'hFFFFFFFF, 32};
        top = '{OP_ADD, 4'b1011, OP_ADD, OP_SHIFTL, OP_SHIFTR,
                OP_SHIFTL, OP_NOTA, OP_SUB, OP_ADD, OP_AND, OP_OR,
                OP_MULT, OP_SHIFTR};
        tsk = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tey = '{'hDEADBEEF, 0, 6, 0, 1, 'h80000000, 'hF0F0F0F0,
                'hFFFFFFFE, 1, 'h00F0, 'hF00F, 1, 0};
        tef = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b00, 2'b10, 2'b00,
                2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        for (int i = 0; i < 13; i++) begin
            do_op(ta[i], tb[i], top[i], tsk[i], y, fl, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL edge%0d_handshake timeout want done", i);
            end
            n_checks++;
            if (y !== tey[i]) begin
                n_fail++;
                $display("FAIL edge%0d_y y=%h want %h", i, y, tey[i]);
            end
            n_checks++;
            if (fl !== tef[i]) begin
                n_fail++;
                $display("FAIL edge%0d_flags bga_bea=%b want %b",
                         i, fl, tef[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] y;
        logic [1:0]  fl;
        bit          ok;
        do_op(2, 2, OP_ADD, 0, y, fl, ok);
        n_checks++;
        if (!ok || y !== 32'd4) begin
            n_fail++;
            $display("FAIL rm_pre ok=%0d y=%h want ok=1 y=4", ok, y);
        end
        req0_a = 100; req0_b = 23; req0_opcode = OP_ADD; req0_valid = 1;
        tick();
        req0_valid = 0;
        #1;
        n_checks++;
        if (rr_ctl !== 7'b1000001) begin
            n_fail++;
            $display("FAIL rm_exec ctl=%b want 1000001", rr_ctl);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (rr_ctl !== 7'b0 || rr_rsp_y !== 32'd0) begin
            n_fail++;
            $display("FAIL rm_async ctl=%b y=%h want 0", rr_ctl, rr_rsp_y);
        end
        tick();
        n_checks++;
        if (rr_ctl !== 7'b0 || rr_rsp_y !== 32'd0) begin
            n_fail++;
            $display("FAIL rm_next ctl=%b y=%h want 0", rr_ctl, rr_rsp_y);
        end
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (rr_ctl !== 7'b0) begin
                n_fail++;
                $display("FAIL rm_idle%0d ctl=%b want 0", c, rr_ctl);
            end
        end
        do_op(100, 23, OP_ADD, 0, y, fl, ok);
        n_checks++;
        if (!ok || y !== 32'd123 || fl !== 2'b00) begin
            n_fail++;
            $display("FAIL rm_fresh ok=%0d y=%0d fl=%b want 1 123 00",
                     ok, y, fl);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_edge_ops();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
